// File: rtl/pcs_link_ctrl.sv
// pcs_link_ctrl: 10GBASE-R style link bring-up / BER monitor controller.
// Sequences transceiver reset-done, block lock and hi_ber into a link state,
// pulses an RX datapath reset on lock timeout, and optionally counts decode
// errors while the link is up (define PCS_LINK_CTRL_ERR_CNT_EN to enable).
module pcs_link_ctrl #(
    parameter int BER_WINDOW   = 39063,
    parameter int BER_THRESH   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RESET_PULSE  = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tx_reset_done_i,
    input  logic        rx_reset_done_i,
    input  logic        rx_lane_locked_i,
    input  logic [1:0]  rxheader_i,
    input  logic        rxheadervalid_i,
    input  logic        decode_error_i,
    input  logic        err_clr_i,
    output logic        rx_datapath_reset_o,
    output logic        tx_enable_o,
    output logic        rx_enable_o,
    output logic        link_up_o,
    output logic        hi_ber_o,
    output logic [2:0]  state_o,
    output logic [15:0] err_count_o
);

    localparam int WIN_W = (BER_WINDOW   > 1) ? $clog2(BER_WINDOW)   : 1;
    localparam int CNT_W = $clog2(BER_THRESH + 1);
    localparam int TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int PUL_W = (RESET_PULSE  > 1) ? $clog2(RESET_PULSE)  : 1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW - 1);
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(BER_THRESH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(RESET_PULSE - 1);

    typedef enum logic [2:0] {
        WAIT_RESET = 3'd0,
        WAIT_LOCK  = 3'd1,
        LINK_UP    = 3'd2,
        HI_BER     = 3'd3,
        RX_RESET   = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   lock_tmr;
    logic [PUL_W-1:0]   pul_cnt;

    // ---------------- BER monitor ----------------
    logic               inv_hdr;
    logic [WIN_W-1:0]   ber_win;
    logic [CNT_W-1:0]   ber_cnt, ber_cnt_nxt;

    assign inv_hdr     = rxheadervalid_i && (rxheader_i == 2'b00 || rxheader_i == 2'b11);
    // count saturates at the threshold; the header on the last window cycle is
    // folded into ber_cnt_nxt so it still counts toward the ending window
    assign ber_cnt_nxt = (inv_hdr && ber_cnt != THRESH_V) ? ber_cnt + CNT_W'(1) : ber_cnt;

    // BER window / error count / hi_ber flag, all held clear while unlocked
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ber_win  <= '0;
            ber_cnt  <= '0;
            hi_ber_o <= 1'b0;
        end else if (!rx_lane_locked_i) begin
            ber_win  <= '0;
            ber_cnt  <= '0;
            hi_ber_o <= 1'b0;
        end else if (ber_win == WIN_LAST) begin
            ber_win  <= '0;
            ber_cnt  <= '0;
            hi_ber_o <= (ber_cnt_nxt == THRESH_V);
        end else begin
            ber_win  <= ber_win + WIN_W'(1);
            ber_cnt  <= ber_cnt_nxt;
            if (ber_cnt_nxt == THRESH_V)
                hi_ber_o <= 1'b1;
        end
    end

    // ---------------- link FSM ----------------
    // next-state decode; outputs are registered from state_nxt below
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_RESET:
                if (tx_reset_done_i && rx_reset_done_i) state_nxt = WAIT_LOCK;
            WAIT_LOCK:
                if (rx_lane_locked_i)                   state_nxt = LINK_UP;
                else if (lock_tmr == TMR_LAST)          state_nxt = RX_RESET;
            LINK_UP:
                if (!rx_reset_done_i)                   state_nxt = WAIT_RESET;
                else if (!rx_lane_locked_i)             state_nxt = WAIT_LOCK;
                else if (hi_ber_o)                      state_nxt = HI_BER;
            HI_BER:
                if (!rx_reset_done_i)                   state_nxt = WAIT_RESET;
                else if (!rx_lane_locked_i)             state_nxt = WAIT_LOCK;
                else if (!hi_ber_o)                     state_nxt = LINK_UP;
            RX_RESET:
                if (pul_cnt == PUL_LAST)                state_nxt = WAIT_RESET;
            default:                                    state_nxt = WAIT_RESET;
        endcase
    end

    // state register, per-state timers and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state               <= WAIT_RESET;
            lock_tmr            <= '0;
            pul_cnt             <= '0;
            link_up_o           <= 1'b0;
            rx_enable_o         <= 1'b0;
            tx_enable_o         <= 1'b0;
            rx_datapath_reset_o <= 1'b0;
        end else begin
            state               <= state_nxt;
            // timers restart on every entry into their state
            lock_tmr            <= (state == WAIT_LOCK && state_nxt == WAIT_LOCK) ? lock_tmr + TMR_W'(1) : '0;
            pul_cnt             <= (state == RX_RESET  && state_nxt == RX_RESET)  ? pul_cnt  + PUL_W'(1) : '0;
            link_up_o           <= (state_nxt == LINK_UP);
            rx_enable_o         <= (state_nxt == LINK_UP);
            tx_enable_o         <= (state_nxt == WAIT_LOCK || state_nxt == LINK_UP || state_nxt == HI_BER);
            rx_datapath_reset_o <= (state_nxt == RX_RESET);
        end
    end

    assign state_o = state;

    // ---------------- decode error counter ----------------
`ifdef PCS_LINK_CTRL_ERR_CNT_EN
    // saturating count of decode errors seen while the link is up; clear wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_count_o <= '0;
        else if (err_clr_i)
            err_count_o <= '0;
        else if (state == LINK_UP && decode_error_i && err_count_o != 16'hFFFF)
            err_count_o <= err_count_o + 16'd1;
    end
`else
    logic unused_err_in;
    assign unused_err_in = decode_error_i ^ err_clr_i;
    assign err_count_o   = '0;
`endif

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// tb_pcs_link_ctrl: directed table + hand sequences for pcs_link_ctrl
// (BER_WINDOW=100, BER_THRESH=16, LOCK_TIMEOUT=50, RESET_PULSE=8).
module tb_pcs_link_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        txd, rxd, lock, hvld, derr, clr;
    logic [1:0]  hdr;
    logic        rx_datapath_reset_o, tx_enable_o, rx_enable_o, link_up_o, hi_ber_o;
    logic [2:0]  state_o;
    logic [15:0] err_count_o;

    int n_cmp = 0;
    int n_err = 0;
    int wcyc;

    pcs_link_ctrl #(
        .BER_WINDOW(100), .BER_THRESH(16), .LOCK_TIMEOUT(50), .RESET_PULSE(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .tx_reset_done_i(txd), .rx_reset_done_i(rxd), .rx_lane_locked_i(lock),
        .rxheader_i(hdr), .rxheadervalid_i(hvld),
        .decode_error_i(derr), .err_clr_i(clr),
        .rx_datapath_reset_o(rx_datapath_reset_o), .tx_enable_o(tx_enable_o),
        .rx_enable_o(rx_enable_o), .link_up_o(link_up_o), .hi_ber_o(hi_ber_o),
        .state_o(state_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    // exp packing: {state[2:0], link_up, rx_en, tx_en, rx_dp_rst, hi_ber}
    typedef struct {
        logic       rst, txd, rxd, lock, hvld;
        logic [1:0] hdr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic hstep(input logic [1:0] h);
        hvld = 1'b1;
        hdr  = h;
        step();
        wcyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; txd = 0; rxd = 0; lock = 0; hvld = 0; hdr = 2'b01; derr = 0; clr = 0;
        step();
        rst = 1'b0;
        step();
    endtask

    // reset, then reach LINK_UP with the locking edge as BER window cycle 0
    task automatic bring_up();
        do_reset();
        txd = 1; rxd = 1;
        step();
        lock = 1;
        step();
        wcyc = 1;
        chk("bringup_state", {29'd0, state_o}, 32'd2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        int n1, n4;
        //        rst txd rxd lock hvld hdr     exp
        tbl[0]  = '{1, 0, 0, 0, 0, 2'b01, 8'b000_00000};
        tbl[1]  = '{0, 0, 0, 0, 0, 2'b01, 8'b000_00000};
        tbl[2]  = '{0, 1, 0, 0, 0, 2'b01, 8'b000_00000}; // only TX done
        tbl[3]  = '{0, 1, 1, 0, 0, 2'b01, 8'b001_00100}; // both done
        tbl[4]  = '{0, 1, 1, 0, 0, 2'b01, 8'b001_00100};
        tbl[5]  = '{0, 1, 1, 1, 0, 2'b01, 8'b010_11100}; // lock
        tbl[6]  = '{0, 1, 1, 1, 1, 2'b10, 8'b010_11100}; // valid header
        tbl[7]  = '{0, 1, 0, 1, 0, 2'b01, 8'b000_00000}; // rx reset-done lost
        tbl[8]  = '{0, 1, 1, 1, 0, 2'b01, 8'b001_00100};
        tbl[9]  = '{0, 1, 1, 1, 0, 2'b01, 8'b010_11100};
        tbl[10] = '{0, 1, 1, 0, 0, 2'b01, 8'b001_00100}; // lock lost

        derr = 0; clr = 0;
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; txd = tbl[i].txd; rxd = tbl[i].rxd; lock = tbl[i].lock;
            hvld = tbl[i].hvld; hdr = tbl[i].hdr;
            step();
            chk($sformatf("vec%0d", i),
                {24'd0, state_o, link_up_o, rx_enable_o, tx_enable_o, rx_datapath_reset_o, hi_ber_o},
                {24'd0, tbl[i].exp});
        end

        // ---- lock timeout: 50 cycles in WAIT_LOCK, 8-cycle RX reset pulse ----
        do_reset();
        chk("reset_state", {29'd0, state_o}, 32'd0);
        txd = 1; rxd = 1;
        step();
        n1 = 0; guard = 0;
        while (state_o == 3'd1 && guard < 200) begin n1++; step(); guard++; end
        chk("wait_lock_cycles", n1, 50);
        chk("timeout_state", {29'd0, state_o}, 32'd4);
        n4 = 0;
        while (rx_datapath_reset_o && guard < 400) begin n4++; step(); guard++; end
        chk("rx_reset_width", n4, 8);
        chk("after_pulse_state", {29'd0, state_o}, 32'd0);

        // ---- async reset aborts a pulse mid-way ----
        guard = 0;
        while (!rx_datapath_reset_o && guard < 200) begin step(); guard++; end
        step(); step();
        chk("abort_pre", {31'd0, rx_datapath_reset_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_rx_rst", {31'd0, rx_datapath_reset_o}, 32'd0);
        chk("abort_state", {29'd0, state_o}, 32'd0);
        step();
        rst = 1'b0;

        // ---- hi_ber entry and exit ----
        bring_up();
        while (wcyc < 16) hstep(2'b11);
        chk("hiber_after15", {31'd0, hi_ber_o}, 32'd0);
        hstep(2'b11);
        chk("hiber_after16", {31'd0, hi_ber_o}, 32'd1);
        chk("hiber_state_lag", {29'd0, state_o}, 32'd2);
        hstep(2'b01);
        chk("hiber_state", {29'd0, state_o}, 32'd3);
        while (wcyc < 199) hstep(2'b10);
        chk("hiber_held", {31'd0, hi_ber_o}, 32'd1);
        hstep(2'b10);
        chk("hiber_cleared", {31'd0, hi_ber_o}, 32'd0);
        chk("hiber_exit_lag", {29'd0, state_o}, 32'd3);
        hstep(2'b10);
        chk("hiber_exit_state", {29'd0, state_o}, 32'd2);

        // ---- threshold boundary at window cycle 99 ----
        lock = 0; hvld = 0;
        step();
        lock = 1;
        step();
        wcyc = 1;
        while (wcyc < 15) hstep(2'b00);
        while (wcyc < 99) hstep(2'b01);
        hstep(2'b00);
        chk("thresh15_hiber", {31'd0, hi_ber_o}, 32'd0);
        chk("thresh15_state", {29'd0, state_o}, 32'd2);
        while (wcyc < 115) hstep(2'b11);
        while (wcyc < 199) hstep(2'b01);
        chk("thresh16_pre", {31'd0, hi_ber_o}, 32'd0);
        hstep(2'b11);
        chk("thresh16_hiber", {31'd0, hi_ber_o}, 32'd1);
        hstep(2'b01);
        chk("thresh16_state", {29'd0, state_o}, 32'd3);

        // ---- lock loss while in HI_BER ----
        lock = 0; hvld = 0;
        step();
        chk("lockloss",
            {27'd0, state_o, hi_ber_o, rx_enable_o, tx_enable_o},
            {27'd0, 3'd1, 1'b0, 1'b0, 1'b1});

        // ---- decode error counter ----
        lock = 1;
        step();
        chk("errcnt_start", {16'd0, err_count_o}, 32'd0);
        derr = 1;
        step(); step(); step();
        derr = 0;
        step();
`ifdef PCS_LINK_CTRL_ERR_CNT_EN
        chk("errcnt_three", {16'd0, err_count_o}, 32'd3);
`else
        chk("errcnt_tied", {16'd0, err_count_o}, 32'd0);
`endif
        derr = 1; clr = 1;
        step();
        derr = 0; clr = 0;
        chk("errcnt_clr", {16'd0, err_count_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
